// File: rtl/register_file_nw_nr_bist_if.sv
// rtl/register_file_nw_nr_bist_if.sv - port bundle for the multi-port register file with BIST
// Purpose : groups the read/write port arrays and the BIST handshake.
// Signals : ReadEnable/ReadAddr/ReadData   - N_READ read ports, registered data
//           WriteEnable/WriteAddr/WriteData - N_WRITE write ports
//           bist_start_i/busy/done/fail/fail_addr - self-test handshake
// Modports: master drives requests (cache / bench), slave is the register file.
interface register_file_nw_nr_bist_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2
);
  logic [N_READ-1:0]                  ReadEnable;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]  ReadAddr;
  logic [N_READ-1:0][DATA_WIDTH-1:0]  ReadData;
  logic [N_WRITE-1:0]                 WriteEnable;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] WriteAddr;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0] WriteData;
  logic                               bist_start_i;
  logic                               bist_busy_o;
  logic                               bist_done_o;
  logic                               bist_fail_o;
  logic [ADDR_WIDTH-1:0]              bist_fail_addr_o;

  modport master (
    output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, bist_start_i,
    input  ReadData, bist_busy_o, bist_done_o, bist_fail_o, bist_fail_addr_o
  );

  modport slave (
    input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, bist_start_i,
    output ReadData, bist_busy_o, bist_done_o, bist_fail_o, bist_fail_addr_o
  );
endinterface

// File: rtl/register_file_nw_nr_bist.sv
// rtl/register_file_nw_nr_bist.sv - flip-flop register file, N write / N read ports, March C- BIST
// Purpose : tag/data storage with registered reads, optional write-to-read bypass
//           and a built-in March C- sequencer.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - register_file_nw_nr_bist_if.slave (read/write ports, BIST handshake)
module register_file_nw_nr_bist #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  register_file_nw_nr_bist_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             addr_q;
  logic                              phase_q;      // 0 = RD cycle, 1 = WR/CMP cycle
  logic                              done_q, fail_q;
  logic [ADDR_WIDTH-1:0]             fail_addr_q;

  logic                              bist_busy, bist_rd, bist_we, bist_cmp;
  logic                              bist_pat_w, bist_pat_r;
  logic                              single, dir_down, elem_last, step, start_acc;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_d;        // post-write value, also the bypass source
  logic [N_READ-1:0]                 rd_en;
  logic [N_READ-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [N_READ-1:0][DATA_WIDTH-1:0] rd_data_q;

  // ---------------- storage ----------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;

    // Ascending loop so the highest-indexed enabled port wins a collision.
    always_comb begin
      word_d = word_q;
      if (bist_busy) begin
        if (bist_we && addr_q == ADDR_WIDTH'(i))
          word_d = {DATA_WIDTH{bist_pat_w}};
      end else begin
        for (int w = 0; w < N_WRITE; w++)
          if (bus.WriteEnable[w] && bus.WriteAddr[w] == ADDR_WIDTH'(i))
            word_d = bus.WriteData[w];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) word_q <= '0;
      else     word_q <= word_d;
    end

    assign mem_q[i] = word_q;
    assign mem_d[i] = word_d;
  end

  // ---------------- read ports ----------------
  // Port 0 is taken over by the sequencer while it runs.
  always_comb begin
    rd_en   = bus.ReadEnable;
    rd_addr = bus.ReadAddr;
    if (bist_busy) begin
      rd_en[0]   = bist_rd;
      rd_addr[0] = addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      for (int r = 0; r < N_READ; r++)
        if (rd_en[r])
          rd_data_q[r] <= (BYPASS != 0) ? mem_d[rd_addr[r]] : mem_q[rd_addr[r]];
    end
  end

  // ---------------- BIST FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- BIST FSM: next state ----------------
  always_comb begin
    single    = (state_q == S_M0);
    dir_down  = (state_q inside {S_M3, S_M4, S_M5});
    elem_last = dir_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    step      = single || phase_q;           // last cycle spent on the current address
    start_acc = (state_q == S_IDLE) && bus.bist_start_i;
    state_d   = state_q;
    case (state_q)
      S_IDLE:  if (bus.bist_start_i) state_d = S_M0;
      S_M0:    if (step && elem_last) state_d = S_M1;
      S_M1:    if (step && elem_last) state_d = S_M2;
      S_M2:    if (step && elem_last) state_d = S_M3;
      S_M3:    if (step && elem_last) state_d = S_M4;
      S_M4:    if (step && elem_last) state_d = S_M5;
      S_M5:    if (step && elem_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- BIST FSM: outputs ----------------
  always_comb begin
    bist_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    bist_rd    = bist_busy && !single && !phase_q;
    bist_we    = single || (bist_busy && phase_q && state_q != S_M5);
    bist_cmp   = bist_busy && !single && phase_q;
    bist_pat_w = (state_q inside {S_M1, S_M3});
    bist_pat_r = (state_q inside {S_M2, S_M4});
  end

  // ---------------- BIST address walk and result flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else if (start_acc) begin
      addr_q      <= '0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else if (bist_busy) begin
      if (step) begin
        phase_q <= 1'b0;
        if (elem_last)
          addr_q <= (state_d inside {S_M3, S_M4, S_M5}) ? ADDR_MAX : '0;
        else
          addr_q <= dir_down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
      end else begin
        phase_q <= 1'b1;
      end
      // ReadData[0] still holds the word fetched in the preceding RD cycle.
      if (bist_cmp && rd_data_q[0] != {DATA_WIDTH{bist_pat_r}}) begin
        fail_q <= 1'b1;
        if (!fail_q) fail_addr_q <= addr_q;
      end
      if (state_q == S_M5 && step && elem_last) done_q <= 1'b1;
    end
  end

  assign bus.ReadData         = rd_data_q;
  assign bus.bist_busy_o      = bist_busy;
  assign bus.bist_done_o      = done_q;
  assign bus.bist_fail_o      = fail_q;
  assign bus.bist_fail_addr_o = fail_addr_q;
endmodule

// File: tb/tb_register_file_nw_nr_bist.sv
// tb/tb_register_file_nw_nr_bist.sv - self-checking bench for register_file_nw_nr_bist
module tb_register_file_nw_nr_bist;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 2 ** AW;
  localparam int BIST_CYCLES = 11 * DEPTH;

  logic clk;
  logic rst;

  register_file_nw_nr_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) bus ();
  register_file_nw_nr_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) nb_bus ();

  register_file_nw_nr_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  register_file_nw_nr_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (nb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] model [DEPTH];
  int          n_tests;
  int          n_fail;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then compare every read issued in the previous cycle.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_eq(e.tag, bus.ReadData[e.port], e.exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ReadEnable     = '0;
    bus.WriteEnable    = '0;
    bus.bist_start_i   = 1'b0;
    nb_bus.ReadEnable  = '0;
    nb_bus.WriteEnable = '0;
    nb_bus.bist_start_i = 1'b0;
  endtask

  task automatic issue_read(input int port, input int addr, input string tag);
    sb_t e;
    bus.ReadEnable[port] = 1'b1;
    bus.ReadAddr[port]   = AW'(addr);
    e.tag = tag; e.port = port; e.exp = model[addr];
    sb_q.push_back(e);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      issue_read(0, a, tag);
      issue_read(1, DEPTH - 1 - a, tag);
      tick();
    end
    bus.ReadEnable = '0;
  endtask

  // Pulses start, optionally stresses the ports while busy, returns busy length.
  task automatic run_bist(input bit stress, output int cyc);
    sb_t e;
    bus.bist_start_i = 1'b1;
    tick();
    bus.bist_start_i = 1'b0;
    chk_eq("start_busy", bus.bist_busy_o, 1);
    chk_eq("start_clears_done", bus.bist_done_o, 0);
    cyc = 0;
    while (bus.bist_busy_o && cyc < 2000) begin
      if (stress) begin
        bus.WriteEnable  = 2'b11;
        bus.WriteAddr[0] = AW'(cyc % DEPTH);
        bus.WriteAddr[1] = AW'(DEPTH - 1);
        bus.WriteData[0] = $urandom;
        bus.WriteData[1] = $urandom | 32'h1;
        bus.ReadEnable[0] = 1'b1;
        bus.ReadAddr[0]   = AW'(DEPTH - 1);
        bus.bist_start_i  = (cyc == 50);
        // M0 clears address 31 only in busy cycle 31, so earlier port-1 reads see old data.
        if (cyc < 30) begin
          bus.ReadEnable[1] = 1'b1;
          bus.ReadAddr[1]   = AW'(DEPTH - 1);
          e.tag = "busy_port1_read"; e.port = 1; e.exp = model[DEPTH - 1];
          sb_q.push_back(e);
        end else begin
          bus.ReadEnable[1] = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    clear_inputs();
  endtask

  initial begin
    int          cyc;
    logic [31:0] d0, d1;
    int          a0, a1;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    clear_inputs();
    bus.ReadAddr = '0; bus.WriteAddr = '0; bus.WriteData = '0;
    nb_bus.ReadAddr = '0; nb_bus.WriteAddr = '0; nb_bus.WriteData = '0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    #1;
    chk_eq("rst_busy", bus.bist_busy_o, 0);
    chk_eq("rst_done", bus.bist_done_o, 0);
    chk_eq("rst_fail", bus.bist_fail_o, 0);
    chk_eq("rst_fail_addr", bus.bist_fail_addr_o, 0);
    chk_eq("rst_rdata0", bus.ReadData[0], 0);
    chk_eq("rst_rdata1", bus.ReadData[1], 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    read_all("reset_read");

    // Write collision: port 1 must win.
    bus.WriteEnable = 2'b11;
    bus.WriteAddr[0] = AW'(3); bus.WriteData[0] = 32'hAAAA_0000;
    bus.WriteAddr[1] = AW'(3); bus.WriteData[1] = 32'h5555_1111;
    tick();
    bus.WriteEnable = '0;
    model[3] = 32'h5555_1111;
    issue_read(0, 3, "collision_p0");
    issue_read(1, 3, "collision_p1");
    tick();
    // Enable low: data holds even though the address moves.
    bus.ReadEnable = '0;
    bus.ReadAddr[0] = AW'(0); bus.ReadAddr[1] = AW'(1);
    begin
      sb_t e;
      e.tag = "hold_p0"; e.port = 0; e.exp = 32'h5555_1111; sb_q.push_back(e);
      e.tag = "hold_p1"; e.port = 1; e.exp = 32'h5555_1111; sb_q.push_back(e);
    end
    tick();
    tick();

    // Random two-port writes with read-back.
    for (int k = 0; k < 8; k++) begin
      a0 = $urandom_range(0, DEPTH - 1);
      a1 = $urandom_range(0, DEPTH - 1);
      d0 = $urandom; d1 = $urandom;
      bus.WriteEnable = 2'b11;
      bus.WriteAddr[0] = AW'(a0); bus.WriteData[0] = d0;
      bus.WriteAddr[1] = AW'(a1); bus.WriteData[1] = d1;
      tick();
      bus.WriteEnable = '0;
      model[a0] = d0;
      model[a1] = d1;
      issue_read(0, a0, "rand_p0");
      issue_read(1, a1, "rand_p1");
      tick();
      bus.ReadEnable = '0;
    end

    // Bypass vs no-bypass on address 7.
    bus.WriteEnable = 2'b01; bus.WriteAddr[0] = AW'(7); bus.WriteData[0] = 32'h1234_5678;
    nb_bus.WriteEnable = 2'b01; nb_bus.WriteAddr[0] = AW'(7); nb_bus.WriteData[0] = 32'h1234_5678;
    tick();
    model[7] = 32'hDEAD_BEEF;
    bus.WriteData[0] = 32'hDEAD_BEEF;
    nb_bus.WriteData[0] = 32'hDEAD_BEEF;
    issue_read(1, 7, "bypass_p1");
    nb_bus.ReadEnable = 2'b10; nb_bus.ReadAddr[1] = AW'(7);
    tick();
    chk_eq("nobypass_p1", nb_bus.ReadData[1], 32'h1234_5678);
    clear_inputs();
    nb_bus.ReadEnable = 2'b10;
    tick();
    chk_eq("nobypass_after", nb_bus.ReadData[1], 32'hDEAD_BEEF);
    nb_bus.ReadEnable = '0;

    // Make sure address 31 holds a nonzero value for the busy-read check.
    bus.WriteEnable = 2'b10; bus.WriteAddr[1] = AW'(31); bus.WriteData[1] = 32'hC0FF_EE31;
    tick();
    bus.WriteEnable = '0;
    model[31] = 32'hC0FF_EE31;

    // Healthy BIST with port stress during busy.
    run_bist(1'b1, cyc);
    chk_eq("bist_cycles", cyc, BIST_CYCLES);
    chk_eq("bist_done", bus.bist_done_o, 1);
    chk_eq("bist_fail", bus.bist_fail_o, 0);
    tick();
    chk_eq("done_sticky", bus.bist_done_o, 1);
    chk_eq("idle_busy", bus.bist_busy_o, 0);
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    read_all("post_bist_zero");

    // Stuck-at-1 on bit 4 of word 9.
    force dut.g_word[9].word_q[4] = 1'b1;
    run_bist(1'b0, cyc);
    chk_eq("stuck_cycles", cyc, BIST_CYCLES);
    chk_eq("stuck_done", bus.bist_done_o, 1);
    chk_eq("stuck_fail", bus.bist_fail_o, 1);
    chk_eq("stuck_fail_addr", bus.bist_fail_addr_o, 9);
    release dut.g_word[9].word_q[4];
    tick();

    // Reset in the middle of a run.
    bus.bist_start_i = 1'b1;
    tick();
    bus.bist_start_i = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    chk_eq("mid_busy_before", bus.bist_busy_o, 1);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_busy", bus.bist_busy_o, 0);
    chk_eq("mid_rst_done", bus.bist_done_o, 0);
    chk_eq("mid_rst_fail", bus.bist_fail_o, 0);
    tick();
    #2;
    rst = 1'b0;
    tick();
    run_bist(1'b0, cyc);
    chk_eq("rerun_cycles", cyc, BIST_CYCLES);
    chk_eq("rerun_done", bus.bist_done_o, 1);
    chk_eq("rerun_fail", bus.bist_fail_o, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
